// File: rtl/switch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared types and constants for the DIP-switch read path.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int SW_WIDTH_MAX            = 24;
    localparam int CHANGED_BIT             = 31;
    localparam int READ_WIDTH              = 32;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 10000;

    // Read word layout: flag on top, 7 reserved zero bits, 24-bit switch field.
    function automatic logic [READ_WIDTH-1:0] pack_read_word(
        input logic                    changed,
        input logic [SW_WIDTH_MAX-1:0] data
    );
        return {changed, 7'b0, data};
    endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/switch_debounce_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : switch_debounce_if
// Description : Switch pins plus I/O read strobe/select and the read word.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_debounce_if #(
    parameter int SW_WIDTH = 24
);
    logic [SW_WIDTH-1:0] switch_i;
    logic                ior;
    logic                switchctrl;
    logic [31:0]         ioread_data_switch;
    logic                switch_changed;

    // Controller / board side drives pins and strobes, consumes the read word.
    modport master (
        output switch_i,
        output ior,
        output switchctrl,
        input  ioread_data_switch,
        input  switch_changed
    );

    modport slave (
        input  switch_i,
        input  ior,
        input  switchctrl,
        output ioread_data_switch,
        output switch_changed
    );
endinterface : switch_debounce_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Parameterised two-flop synchroniser, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/switch_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Synchronise, vector-debounce and hold DIP switches; expose
//               them as the 32-bit switch read word with a sticky change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_pkg::*;
#(
    parameter int SW_WIDTH        = 24,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = 20
) (
    input  logic             clock,
    input  logic             reset,
    switch_debounce_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    generate
        if (SW_WIDTH < 1 || SW_WIDTH > SW_WIDTH_MAX) begin : g_bad_sw_width
            $error("switch_debounce: SW_WIDTH must be 1..24");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
            $error("switch_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
        if ((64'd1 << CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_width
            $error("switch_debounce: CNT_WIDTH too narrow for DEBOUNCE_CYCLES");
        end
    endgenerate

    logic [SW_WIDTH-1:0]  w_s2;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [SW_WIDTH-1:0]  r_cand;
    logic [SW_WIDTH-1:0]  w_cand_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [SW_WIDTH-1:0]  r_stable;
    logic [SW_WIDTH-1:0]  w_stable_nxt;
    logic                 r_changed;
    logic                 w_changed_nxt;
    logic                 w_commit;
    logic                 w_read;

    sync_2ff #(
        .WIDTH (SW_WIDTH)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.switch_i),
        .q     (w_s2)
    );

    assign w_read = bus.ior & bus.switchctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= STABLE;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stable  <= w_stable_nxt;
            r_changed <= w_changed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_commit     = 1'b0;

        case (r_state)
            STABLE: begin
                if (w_s2 != r_stable) begin
                    w_cand_nxt  = w_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_s2 == r_stable) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STABLE;
                end else if (w_s2 != r_cand) begin
                    // Any bit still bouncing restarts the whole window.
                    w_cand_nxt = w_s2;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_stable_nxt = r_cand;
                    w_commit     = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = STABLE;
            end
        endcase

        // A read coinciding with a commit returned the old value, so set wins.
        w_changed_nxt = r_changed;
        if (w_commit) begin
            w_changed_nxt = 1'b1;
        end else if (w_read) begin
            w_changed_nxt = 1'b0;
        end
    end

    assign bus.ioread_data_switch = pack_read_word(r_changed, SW_WIDTH_MAX'(r_stable));
    assign bus.switch_changed     = r_changed;

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce
// Description : Directed self-checking bench, DEBOUNCE_CYCLES=4, SW_WIDTH=24.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    switch_debounce_if #(.SW_WIDTH(24)) bus ();

    switch_debounce #(
        .SW_WIDTH        (24),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_check(input int n, input string tag, input logic [31:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, bus.ioread_data_switch, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("rst_immediate", bus.ioread_data_switch, 32'h0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bus.switch_i   = 24'hFFFFFF;
        bus.ior        = 1'b0;
        bus.switchctrl = 1'b0;
        reset          = 1'b0;

        // Reset value, pins high while held in reset
        #1;
        check("rst_async", bus.ioread_data_switch, 32'h0);
        run_check(3, "rst_hold", 32'h0);
        bus.switch_i = 24'h0;
        reset        = 1'b1;
        run_check(8, "rst_release", 32'h0);
        check("rst_flag", {31'b0, bus.switch_changed}, 32'h0);

        // Clean change: commit on edge 7
        bus.switch_i = 24'h00A5C3;
        run_check(6, "clean_wait", 32'h0);
        tick();
        check("clean_commit", bus.ioread_data_switch, 32'h8000A5C3);
        check("clean_flag", {31'b0, bus.switch_changed}, 32'h1);

        // Read clear needs both strobe and select
        bus.ior = 1'b1; bus.switchctrl = 1'b0;
        tick();
        check("read_no_cs", bus.ioread_data_switch, 32'h8000A5C3);
        bus.ior = 1'b0; bus.switchctrl = 1'b1;
        tick();
        check("read_no_ior", bus.ioread_data_switch, 32'h8000A5C3);
        bus.ior = 1'b1;
        tick();
        check("read_clear", bus.ioread_data_switch, 32'h0000A5C3);
        check("read_clear_flag", {31'b0, bus.switch_changed}, 32'h0);
        bus.ior = 1'b0; bus.switchctrl = 1'b0;
        tick();
        check("read_idle", bus.ioread_data_switch, 32'h0000A5C3);

        // Bounce on bit0, then settle at 1
        bus.switch_i = 24'h0;
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            bus.switch_i = (k % 2 == 0) ? 24'h000001 : 24'h000000;
            run_check(2, "bounce", 32'h0);
        end
        bus.switch_i = 24'h000001;
        run_check(6, "bounce_settle", 32'h0);
        tick();
        check("bounce_commit", bus.ioread_data_switch, 32'h80000001);

        // Glitch of 3 cycles is rejected
        bus.switch_i = 24'h0;
        pulse_reset();
        bus.switch_i = 24'h000010;
        run_check(3, "glitch_pulse", 32'h0);
        bus.switch_i = 24'h0;
        run_check(10, "glitch_after", 32'h0);
        check("glitch_flag", {31'b0, bus.switch_changed}, 32'h0);

        // Read strobe on the commit edge: set wins
        bus.switch_i = 24'h000042;
        run_check(6, "simul_wait", 32'h0);
        bus.ior = 1'b1; bus.switchctrl = 1'b1;
        tick();
        check("simul_commit_read", bus.ioread_data_switch, 32'h80000042);
        tick();
        check("simul_next_read", bus.ioread_data_switch, 32'h00000042);
        bus.ior = 1'b0; bus.switchctrl = 1'b0;

        // Reset mid-SETTLE (cnt=2 after edge 5) discards progress
        bus.switch_i = 24'h000777;
        run_check(5, "settle_pre_rst", 32'h00000042);
        reset = 1'b0;
        #1;
        check("settle_rst_async", bus.ioread_data_switch, 32'h0);
        check("settle_rst_flag", {31'b0, bus.switch_changed}, 32'h0);
        tick();
        check("settle_rst_hold", bus.ioread_data_switch, 32'h0);
        reset = 1'b1;
        run_check(6, "settle_recount", 32'h0);
        tick();
        check("settle_recommit", bus.ioread_data_switch, 32'h80000777);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_switch_debounce
`default_nettype wire
